// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - instruction sequencer for the 16-bit ALU/register-file/RAM datapath
// Fetches instruction words over imem_req/imem_ack, decodes them onto alu_op/alu_a/alu_b,
// strobes rf_we (load) or ram_we (store) for one MEM cycle and latches the {C,V,Z} flags.
// Optional SINGLE_STEP_EN: adds input step and a STEP state that pauses after each retire.
// Ports:
//   clk, init (async active-low reset), start, step (SINGLE_STEP_EN only)
//   imem_req, imem_addr, imem_ack, imem_data   instruction fetch handshake
//   alu_op, alu_a, alu_b                       decoded datapath controls
//   alu_c, alu_v, alu_z                        datapath status inputs
//   rf_we, ram_we                              write strobes
//   flags, pc, busy, halted, illegal, fault    sequencer status
module alu_sequencer #(
  parameter int unsigned PC_W          = 10,
  parameter int unsigned RESET_PC      = 0,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            init,
  input  logic            start,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [3:0]      alu_op,
  output logic [2:0]      alu_a,
  output logic [2:0]      alu_b,
  input  logic            alu_c,
  input  logic            alu_v,
  input  logic            alu_z,
  output logic            rf_we,
  output logic            ram_we,
  output logic [2:0]      flags,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic            fault
);

`ifdef SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT, S_STEP
  } state_t;
  // Retired instructions park in STEP with the fetch request and busy low.
  localparam state_t RETIRE_ST  = S_STEP;
  localparam logic   RETIRE_RUN = 1'b0;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
  } state_t;
  localparam state_t RETIRE_ST  = S_FETCH;
  localparam logic   RETIRE_RUN = 1'b1;
`endif

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
  // Counter value on the last permitted FETCH cycle without ack.
  localparam logic [7:0]      TO_LAST    = 8'(FETCH_TIMEOUT - 1);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc_d;
  logic [9:0]      ir_q;      // only op/op1/op2 are kept; imem_data[5:0] is don't-care
  logic [7:0]      tmo_q;
  logic [3:0]      alu_op_q;
  logic [2:0]      alu_a_q;
  logic [2:0]      alu_b_q;
  logic [2:0]      flags_q;
  logic            req_q;
  logic            rf_we_q;
  logic            ram_we_q;
  logic            busy_q;
  logic            halted_q;
  logic            illegal_q;
  logic            fault_q;
  logic            unused_imem_bits;

  assign unused_imem_bits = ^imem_data[5:0];
  // Wraps modulo 2^PC_W by construction.
  assign pc_inc_d = pc_q + PC_W'(1);

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC_V;
      ir_q      <= '0;
      tmo_q     <= '0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      flags_q   <= '0;
      req_q     <= 1'b0;
      rf_we_q   <= 1'b0;
      ram_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_data[15:6];
            tmo_q   <= '0;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end else if (tmo_q == TO_LAST) begin
            tmo_q    <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_DECODE: begin
          alu_op_q <= ir_q[9:6];
          alu_a_q  <= ir_q[5:3];
          alu_b_q  <= ir_q[2:0];
          case (ir_q[9:6])
            4'b1111: begin
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            4'b0100, 4'b1100, 4'b1101, 4'b1110: begin
              // Illegal opcodes retire as NOPs.
              illegal_q <= 1'b1;
              pc_q      <= pc_inc_d;
              req_q     <= RETIRE_RUN;
              busy_q    <= RETIRE_RUN;
              state_q   <= RETIRE_ST;
            end
            4'b0101: begin
              ram_we_q <= 1'b1;
              state_q  <= S_MEM;
            end
            4'b0110: begin
              rf_we_q <= 1'b1;
              state_q <= S_MEM;
            end
            default: state_q <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          flags_q <= {alu_c, alu_v, alu_z};
          pc_q    <= pc_inc_d;
          req_q   <= RETIRE_RUN;
          busy_q  <= RETIRE_RUN;
          state_q <= RETIRE_ST;
        end
        S_MEM: begin
          // Strobes were raised on entry, so they span this whole cycle.
          rf_we_q  <= 1'b0;
          ram_we_q <= 1'b0;
          pc_q     <= pc_inc_d;
          req_q    <= RETIRE_RUN;
          busy_q   <= RETIRE_RUN;
          state_q  <= RETIRE_ST;
        end
        S_HALT: begin
          if (start) begin
            pc_q      <= RESET_PC_V;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
`ifdef SINGLE_STEP_EN
        S_STEP: begin
          if (step) begin
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rf_we     = rf_we_q;
  assign ram_we    = ram_we_q;
  assign flags     = flags_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed scoreboard bench for alu_sequencer
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (PC_W=10)
  logic        init, start, alu_c, alu_v, alu_z;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic        imem_req, rf_we, ram_we, busy, halted, illegal, fault;
  logic [9:0]  imem_addr, pc;
  logic [3:0]  alu_op;
  logic [2:0]  alu_a, alu_b, flags;

  // Wrap instance (PC_W=4)
  logic        init4, start4, c4, v4, z4;
  logic        imem_ack4 = 1'b0;
  logic [15:0] imem_data4 = '0;
  logic        imem_req4, rf_we4, ram_we4, busy4, halted4, illegal4, fault4;
  logic [3:0]  imem_addr4, pc4;
  logic [3:0]  alu_op4;
  logic [2:0]  alu_a4, alu_b4, flags4;

`ifdef SINGLE_STEP_EN
  logic step = 1'b1;
  logic step4 = 1'b1;
`endif

  alu_sequencer u_dut (
    .clk(clk), .init(init), .start(start),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z),
    .rf_we(rf_we), .ram_we(ram_we), .flags(flags), .pc(pc),
    .busy(busy), .halted(halted), .illegal(illegal), .fault(fault)
  );

  alu_sequencer #(.PC_W(4)) u_dut4 (
    .clk(clk), .init(init4), .start(start4),
`ifdef SINGLE_STEP_EN
    .step(step4),
`endif
    .imem_req(imem_req4), .imem_addr(imem_addr4), .imem_ack(imem_ack4), .imem_data(imem_data4),
    .alu_op(alu_op4), .alu_a(alu_a4), .alu_b(alu_b4),
    .alu_c(c4), .alu_v(v4), .alu_z(z4),
    .rf_we(rf_we4), .ram_we(ram_we4), .flags(flags4), .pc(pc4),
    .busy(busy4), .halted(halted4), .illegal(illegal4), .fault(fault4)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: fetch addresses and write-strobe events
  typedef struct packed {
    logic       rf;
    logic       ram;
    logic [3:0] op;
    logic [2:0] a;
    logic [2:0] b;
  } strobe_t;

  logic [9:0] fetch_q[$];
  strobe_t    strobe_q[$];

  // Instruction memory with programmable ack latency
  logic [15:0] mem [1024];
  logic [15:0] mem4 [16];
  bit          ack_en    = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt  = 0;

  always @(negedge clk) begin
    imem_ack = 1'b0;
    if (imem_req && ack_en) begin
      if (wait_cnt == ack_delay) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        wait_cnt  = 0;
        check("fetch_pending", 32'(fetch_q.size() != 0), 32'(1));
        if (fetch_q.size() != 0) check("fetch_addr", 32'(imem_addr), 32'(fetch_q.pop_front()));
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    imem_ack4  = imem_req4;
    imem_data4 = mem4[imem_addr4];
  end

  always @(negedge clk) begin
    if (rf_we || ram_we) begin
      check("strobe_exclusive", 32'(rf_we & ram_we), 32'(0));
      check("strobe_pending", 32'(strobe_q.size() != 0), 32'(1));
      if (strobe_q.size() != 0)
        check("strobe_event", 32'({rf_we, ram_we, alu_op, alu_a, alu_b}), 32'(strobe_q.pop_front()));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted(input string tag);
    int n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(halted), 32'(1));
  endtask

  task automatic push_fetches(input int last);
    for (int i = 0; i <= last; i++) fetch_q.push_back(10'(i));
  endtask

  // {halted, rf_we, busy, alu_op, flags, pc[3:0]} after each edge of the add/load/halt run
  logic [13:0] exp_tr [9];

  initial begin
    int n;
    bit addr_ok;

    exp_tr[0] = {1'b0, 1'b0, 1'b1, 4'h0, 3'b000, 4'd0};
    exp_tr[1] = {1'b0, 1'b0, 1'b1, 4'h0, 3'b000, 4'd0};
    exp_tr[2] = {1'b0, 1'b0, 1'b1, 4'h3, 3'b000, 4'd0};
    exp_tr[3] = {1'b0, 1'b0, 1'b1, 4'h3, 3'b101, 4'd1};
    exp_tr[4] = {1'b0, 1'b0, 1'b1, 4'h3, 3'b101, 4'd1};
    exp_tr[5] = {1'b0, 1'b1, 1'b1, 4'h6, 3'b101, 4'd1};
    exp_tr[6] = {1'b0, 1'b0, 1'b1, 4'h6, 3'b101, 4'd2};
    exp_tr[7] = {1'b0, 1'b0, 1'b1, 4'h6, 3'b101, 4'd2};
    exp_tr[8] = {1'b1, 1'b0, 1'b0, 4'hF, 3'b101, 4'd2};

    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
    mem4[15] = 16'h3280;

    init = 1'b0; start = 1'b0;
    alu_c = 1'b1; alu_v = 1'b0; alu_z = 1'b1;
    init4 = 1'b0; start4 = 1'b0;
    c4 = 1'b0; v4 = 1'b0; z4 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc", 32'(pc), 32'(0));
    check("rst_status", 32'({imem_req, rf_we, ram_we, busy, halted, illegal, fault}), 32'(0));
    check("rst_flags_op", 32'({flags, alu_op, alu_a, alu_b}), 32'(0));
    init = 1'b1;
    @(negedge clk);

    // add r1,r2 / load r3,r4 / halt with zero-wait ack
    mem[0] = 16'h3280;
    mem[1] = 16'h6700;
    mem[2] = 16'hF000;
    push_fetches(2);
    strobe_q.push_back('{rf: 1'b1, ram: 1'b0, op: 4'h6, a: 3'd3, b: 3'd4});
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("trace_%0d", k),
            32'({halted, rf_we, busy, alu_op, flags, pc[3:0]}), 32'(exp_tr[k]));
    end

    // Restart from HALT with a 5-cycle ack delay
    ack_delay = 5;
    push_fetches(2);
    strobe_q.push_back('{rf: 1'b1, ram: 1'b0, op: 4'h6, a: 3'd3, b: 3'd4});
    pulse_start();
    check("restart_halted_clear", 32'(halted), 32'(0));
    n = 0;
    addr_ok = 1'b1;
    while (imem_req && n < 20) begin
      if (imem_addr != 10'd0) addr_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check("delay_req_cycles", 32'(n), 32'(6));
    check("delay_addr_stable", 32'(addr_ok), 32'(1));
    check("delay_no_fault", 32'(fault), 32'(0));
    wait_halted("delay_run_halted");
    check("delay_run_pc", 32'(pc), 32'(2));
    ack_delay = 0;

    // Fetch timeout
    ack_en = 1'b0;
    pulse_start();
    repeat (14) @(negedge clk);
    check("tmo_before_fault", 32'({fault, halted, imem_req}), 32'(3'b001));
    @(negedge clk);
    check("tmo_fault", 32'({fault, halted, busy, imem_req}), 32'(4'b1100));
    ack_en = 1'b1;
    push_fetches(2);
    strobe_q.push_back('{rf: 1'b1, ram: 1'b0, op: 4'h6, a: 3'd3, b: 3'd4});
    pulse_start();
    check("tmo_restart", 32'({fault, halted, imem_req}), 32'(3'b001));
    check("tmo_restart_pc", 32'(pc), 32'(0));
    wait_halted("tmo_rerun_halted");

    // Illegal opcode at address 5 followed by a store
    for (int i = 0; i < 5; i++) mem[i] = 16'h0000;
    mem[5] = 16'h4000;
    mem[6] = 16'h5440;
    mem[7] = 16'hF000;
    push_fetches(7);
    strobe_q.push_back('{rf: 1'b0, ram: 1'b1, op: 4'h5, a: 3'd2, b: 3'd1});
    pulse_start();
    check("ill_clear_on_start", 32'(illegal), 32'(0));
    n = 0;
    while (!(imem_req && imem_addr == 10'd6) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ill_next_fetch_pc", 32'(imem_addr), 32'(6));
    check("ill_sticky_set", 32'({illegal, rf_we, ram_we}), 32'(3'b100));
    wait_halted("ill_run_halted");
    check("ill_end", 32'({illegal, fault}), 32'(2'b10));
    check("ill_end_pc", 32'(pc), 32'(7));

    // Reset in the middle of the store's MEM cycle
    push_fetches(6);
    strobe_q.push_back('{rf: 1'b0, ram: 1'b1, op: 4'h5, a: 3'd2, b: 3'd1});
    pulse_start();
    n = 0;
    while (!ram_we && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midmem_ram_we_seen", 32'(ram_we), 32'(1));
    check("midmem_flags_before", 32'(flags), 32'(3'b101));
    #2 init = 1'b0;
    #1;
    check("midmem_ram_we_drop", 32'(ram_we), 32'(0));
    check("midmem_pc", 32'(pc), 32'(0));
    check("midmem_flags", 32'(flags), 32'(0));
    check("midmem_status", 32'({imem_req, busy, halted, rf_we}), 32'(0));
    @(negedge clk);
    init = 1'b1;
    repeat (3) @(negedge clk);
    check("midmem_idle_hold", 32'({imem_req, busy, pc}), 32'(0));
    check("sb_fetch_empty", 32'(fetch_q.size()), 32'(0));
    check("sb_strobe_empty", 32'(strobe_q.size()), 32'(0));

    // PC_W=4: add at address 15 wraps the next fetch to 0
    init4 = 1'b1;
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!(imem_req4 && imem_addr4 == 4'd15) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wrap_reach_15", 32'(imem_addr4), 32'(15));
    check("wrap_flags_before", 32'(flags4), 32'(0));
    c4 = 1'b0; v4 = 1'b1; z4 = 1'b0;
    @(negedge clk);
    n = 0;
    while (!imem_req4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wrap_req", 32'(imem_req4), 32'(1));
    check("wrap_addr", 32'(imem_addr4), 32'(0));
    check("wrap_flags", 32'(flags4), 32'(3'b010));
    check("wrap_no_fault", 32'({fault4, halted4}), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
